// File: rtl/vga_pkg.sv
// Shared timing defaults, the per-pixel scan flag bundle and image sizing helper
// for the VGA frame scanner.
package vga_pkg;

    localparam int CW = 12;

    localparam int H_VIS_D  = 640;
    localparam int H_FP_D   = 16;
    localparam int H_SYNC_D = 96;
    localparam int H_BP_D   = 48;
    localparam int V_VIS_D  = 480;
    localparam int V_FP_D   = 10;
    localparam int V_SYNC_D = 2;
    localparam int V_BP_D   = 33;

    localparam int IMG_W_D  = 256;
    localparam int IMG_H_D  = 256;
    localparam int IMG_X0_D = 192;
    localparam int IMG_Y0_D = 112;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic win;
        logic fs;
    } scan_flags_t;

    function automatic logic [31:0] img_words(input int w, input int h);
        return 32'(w * h);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with enable hold and stage-0 flag decode.
// With VGA_TEST_PATTERN_EN defined it also produces the h^v test pattern gray.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_D,
    parameter int H_FP   = H_FP_D,
    parameter int H_SYNC = H_SYNC_D,
    parameter int H_BP   = H_BP_D,
    parameter int V_VIS  = V_VIS_D,
    parameter int V_FP   = V_FP_D,
    parameter int V_SYNC = V_SYNC_D,
    parameter int V_BP   = V_BP_D,
    parameter int IMG_W  = IMG_W_D,
    parameter int IMG_H  = IMG_H_D,
    parameter int IMG_X0 = IMG_X0_D,
    parameter int IMG_Y0 = IMG_Y0_D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
`ifdef VGA_TEST_PATTERN_EN
    output logic [7:0]  gray,
`endif
    output scan_flags_t flags
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_cnt == CW'(H_TOT - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == CW'(V_TOT - 1)) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        flags     = '0;
        flags.vis = (h_cnt < CW'(H_VIS)) && (v_cnt < CW'(V_VIS));
        flags.hs  = (h_cnt >= CW'(H_VIS + H_FP)) && (h_cnt < CW'(H_VIS + H_FP + H_SYNC));
        flags.vs  = (v_cnt >= CW'(V_VIS + V_FP)) && (v_cnt < CW'(V_VIS + V_FP + V_SYNC));
        flags.win = (h_cnt >= CW'(IMG_X0)) && (h_cnt < CW'(IMG_X0 + IMG_W)) &&
                    (v_cnt >= CW'(IMG_Y0)) && (v_cnt < CW'(IMG_Y0 + IMG_H));
        flags.fs  = (h_cnt == '0) && (v_cnt == '0);
    end

`ifdef VGA_TEST_PATTERN_EN
    assign gray = h_cnt[7:0] ^ v_cnt[7:0];
`endif

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA scanner top: VRAM address generation, flag delay line and registered outputs.
// Optional test pattern input selected by the VGA_TEST_PATTERN_EN macro.
module vga_frame_scanner
    import vga_pkg::*;
#(
    parameter int          H_VIS     = H_VIS_D,
    parameter int          H_FP      = H_FP_D,
    parameter int          H_SYNC    = H_SYNC_D,
    parameter int          H_BP      = H_BP_D,
    parameter int          V_VIS     = V_VIS_D,
    parameter int          V_FP      = V_FP_D,
    parameter int          V_SYNC    = V_SYNC_D,
    parameter int          V_BP      = V_BP_D,
    parameter int          IMG_W     = IMG_W_D,
    parameter int          IMG_H     = IMG_H_D,
    parameter int          IMG_X0    = IMG_X0_D,
    parameter int          IMG_Y0    = IMG_Y0_D,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [7:0]  pixel_in,
    output logic [31:0] gpu_address,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start
);

    localparam int          QD        = RD_LAT + 1;
    localparam logic [31:0] IMG_WORDS = img_words(IMG_W, IMG_H);

    if (IMG_X0 + IMG_W > H_VIS || IMG_Y0 + IMG_H > V_VIS) begin : g_bad_window
        $error("vga_frame_scanner: image window exceeds the visible area");
    end
    if ({1'b0, BASE_ADDR} + {1'b0, IMG_WORDS} > 33'h1_0000_0000) begin : g_bad_base
        $error("vga_frame_scanner: image does not fit in the address space");
    end
    if (RD_LAT < 1 || RD_LAT > 100) begin : g_bad_lat
        $error("vga_frame_scanner: RD_LAT out of range");
    end

    scan_flags_t flags;
    scan_flags_t dly [QD];
    logic [31:0] pix_addr;
    logic [31:0] addr_base;
    logic [QD-1:0] en_sr;
    logic [7:0]  rd_q [QD];
    logic [7:0]  rd_cnt;
    logic [7:0]  fill;
    logic [7:0]  wr_idx;
    logic [7:0]  pix;
    logic [7:0]  colour;
    logic        push;
    logic        pop;

`ifdef VGA_TEST_PATTERN_EN
    logic [7:0]  gray;
    logic [7:0]  gray_d [QD];
    logic [QD-1:0] tp_d;
`endif

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
`ifdef VGA_TEST_PATTERN_EN
        .gray   (gray),
`endif
        .flags  (flags)
    );

    // Stage 0: issue the VRAM read for the current scan position.
    assign addr_base = flags.fs ? 32'd0 : pix_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_addr    <= '0;
            gpu_address <= BASE_ADDR;
        end else if (enable) begin
            if (flags.win) begin
                gpu_address <= BASE_ADDR + addr_base;
                pix_addr    <= addr_base + 32'd1;
            end else if (flags.fs) begin
                pix_addr <= '0;
            end
        end
    end

    // Stages 1..RD_LAT+1: flags wait for the read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QD; i++) dly[i] <= '0;
        end else if (enable) begin
            dly[0] <= flags;
            for (int i = 1; i < QD; i++) dly[i] <= dly[i-1];
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QD; i++) gray_d[i] <= '0;
            tp_d <= '0;
        end else if (enable) begin
            gray_d[0] <= gray;
            tp_d[0]   <= test_mode;
            for (int i = 1; i < QD; i++) begin
                gray_d[i] <= gray_d[i-1];
                tp_d[i]   <= tp_d[i-1];
            end
        end
    end
`endif

    // The read port keeps returning data while the scan is frozen; those in-flight
    // bytes are parked here so they still meet their flags once the scan resumes.
    assign push   = en_sr[QD-1];
    assign pop    = enable && (fill == 8'(QD));
    assign wr_idx = rd_cnt - {7'd0, pop};
    assign pix    = (rd_cnt == 8'd0) ? pixel_in : rd_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sr  <= '0;
            fill   <= '0;
            rd_cnt <= '0;
            for (int i = 0; i < QD; i++) rd_q[i] <= '0;
        end else begin
            en_sr[0] <= enable;
            for (int i = 1; i < QD; i++) en_sr[i] <= en_sr[i-1];
            if (enable && fill != 8'(QD)) fill <= fill + 8'd1;
            rd_cnt <= rd_cnt + {7'd0, push} - {7'd0, pop};
            for (int i = 0; i < QD; i++) begin
                if (pop && i < QD - 1) rd_q[i] <= rd_q[i+1];
                if (push && wr_idx == 8'(i)) rd_q[i] <= pixel_in;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    assign colour = tp_d[QD-1] ? gray_d[QD-1] : pix;
`else
    assign colour = pix;
`endif

    // Output stage: registered sync, blanking and colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= ~dly[QD-1].hs;
            vsync       <= ~dly[QD-1].vs;
            blank_n     <= dly[QD-1].vis;
            red         <= dly[QD-1].win ? colour : 8'd0;
            green       <= dly[QD-1].win ? colour : 8'd0;
            blue        <= dly[QD-1].win ? colour : 8'd0;
            frame_start <= dly[QD-1].fs;
        end
    end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Scoreboard bench for vga_frame_scanner on a reduced raster; define
// VGA_TEST_PATTERN_EN on both files to exercise test_mode.
`timescale 1ns/1ps
module tb_vga_frame_scanner;

    localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int V_VIS = 30, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int IMG_W = 24, IMG_H = 20, IMG_X0 = 10, IMG_Y0 = 6;
    localparam logic [31:0] BASE = 32'd3;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int P_FREE  = 3 + 4 * FRAME;
    localparam int P_HOLD  = P_FREE + 17 * H_TOT + 5;
    localparam int P_RST   = P_HOLD + 300;
    localparam int P_RAND  = P_HOLD + 1000;
    localparam int NCYC    = P_RAND + 20000;

    typedef struct packed {
        logic [31:0] addr;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        fs;
    } obs_t;

    typedef struct {
        logic       vis, hs, vs, win, fs;
        logic [7:0] col;
    } pos_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        test_mode = 1'b0;
    logic [7:0]  pixel_in = 8'd0;
    logic [31:0] gpu_address;
    logic        hsync, vsync, blank_n, frame_start;
    logic [7:0]  red, green, blue;

    obs_t        exp_q[$];
    pos_t        hist[$];
    int          scan_n = 0;
    logic [31:0] last_addr = BASE;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    // VRAM: each word holds the low byte of its own address, one cycle of latency.
    always @(posedge clk) pixel_in <= gpu_address[7:0];

    vga_frame_scanner #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
        .BASE_ADDR(BASE), .RD_LAT(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .pixel_in    (pixel_in),
        .gpu_address (gpu_address),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    function automatic pos_t classify(input int idx, input logic tm);
        pos_t p;
        int h, v;
        h = idx % H_TOT;
        v = idx / H_TOT;
        p.vis = (h < H_VIS) && (v < V_VIS);
        p.hs  = (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC);
        p.vs  = (v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC);
        p.win = (h >= IMG_X0) && (h < IMG_X0 + IMG_W) && (v >= IMG_Y0) && (v < IMG_Y0 + IMG_H);
        p.fs  = (idx == 0);
        if (!p.win)  p.col = 8'd0;
        else if (tm) p.col = 8'(h ^ v);
        else         p.col = 8'(BASE + 32'((v - IMG_Y0) * IMG_W + (h - IMG_X0)));
        return p;
    endfunction

    // Expected outputs after the coming clock edge; output lags the scan by three enabled edges.
    function automatic obs_t model_step(input logic r, input logic en);
        obs_t o;
        pos_t p;
        int h, v;
        if (r) begin
            scan_n = 0;
            hist.delete();
            last_addr = BASE;
        end else if (en) begin
            p = classify(scan_n, test_mode);
            hist.push_back(p);
            if (hist.size() > 3) void'(hist.pop_front());
            if (p.win) begin
                h = scan_n % H_TOT;
                v = scan_n / H_TOT;
                last_addr = BASE + 32'((v - IMG_Y0) * IMG_W + (h - IMG_X0));
            end
            scan_n = (scan_n + 1) % FRAME;
        end
        o = '{addr: last_addr, hs: 1'b1, vs: 1'b1, bn: 1'b0, r: 8'd0, g: 8'd0, b: 8'd0, fs: 1'b0};
        if (!r && en && hist.size() == 3) begin
            o.hs = ~hist[0].hs;
            o.vs = ~hist[0].vs;
            o.bn = hist[0].vis;
            o.r  = hist[0].col;
            o.g  = hist[0].col;
            o.b  = hist[0].col;
            o.fs = hist[0].fs;
        end
        return o;
    endfunction

    initial begin : monitor
        obs_t e, a;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {gpu_address, hsync, vsync, blank_n, red, green, blue, frame_start};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL outputs cyc=%0d: got addr=%0d hs=%b vs=%b bn=%b rgb=%h/%h/%h fs=%b, want addr=%0d hs=%b vs=%b bn=%b rgb=%h/%h/%h fs=%b",
                             cyc, a.addr, a.hs, a.vs, a.bn, a.r, a.g, a.b, a.fs,
                             e.addr, e.hs, e.vs, e.bn, e.r, e.g, e.b, e.fs);
                end
                cyc++;
            end
        end
    end

    initial begin : driver
        int hold_left, rst_left;
        hold_left = 0;
        rst_left  = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (c < 3) begin
                rst = 1'b1;
                enable = 1'b1;
            end else if (c < P_HOLD) begin
                rst = 1'b0;
                enable = 1'b1;
            end else if (c < P_HOLD + 50) begin
                enable = 1'b0;
            end else if (c < P_RST) begin
                enable = 1'b1;
            end else if (c < P_RST + 3) begin
                rst = 1'b1;
            end else if (c < P_RAND) begin
                rst = 1'b0;
            end else begin
                if (rst_left > 0) begin
                    rst_left--;
                    rst = (rst_left != 0);
                end else if ($urandom_range(0, 2999) == 0) begin
                    rst = 1'b1;
                    rst_left = 2;
                end
                if (hold_left > 0) begin
                    hold_left--;
                    enable = 1'b0;
                end else if ($urandom_range(0, 99) < 4) begin
                    hold_left = $urandom_range(0, 11);
                    enable = 1'b0;
                end else begin
                    enable = 1'b1;
                end
`ifdef VGA_TEST_PATTERN_EN
                if ($urandom_range(0, 399) == 0) test_mode = ~test_mode;
`endif
            end
            exp_q.push_back(model_step(rst, enable));
        end
        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
